// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg -- shared types and constants for the SPI master controller slice.
//
// Contents:
//   CLK_DIV_DEFAULT : default sclk half-period in clk_i cycles
//   BITS_PER_BYTE   : bits shifted per transfer
//   spi_state_e     : controller FSM state encoding (exported on dbg_state_o)
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int CLK_DIV_DEFAULT = 4;
  localparam int BITS_PER_BYTE   = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_CS_HOLD  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// ---------------------------------------------------------------------------
// spi_clk_div -- sclk generator for the SPI master controller.
//
// While en_i is high the divider counts clk_i cycles and flips the sclk level
// every CLK_DIV cycles. The level register rests at 0 while disabled, so the
// first enabled cycle already shows sclk low: the falling edge that opens a
// byte coincides with the first cycle of SHIFT. While disabled sclk_o idles
// high.
//
// Ports:
//   clk_i, rst_i   : system clock, asynchronous active-high reset
//   en_i           : run the divider (controller is in SHIFT)
//   sclk_o         : SPI clock level (1 while disabled)
//   fall_o         : high in the clk_i cycle in which sclk_o has just fallen
//   rise_o         : high in the clk_i cycle in which sclk_o has just risen
//   period_end_o   : last clk_i cycle of an sclk high phase (full period end)
// ---------------------------------------------------------------------------
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sclk_o,
  output logic fall_o,
  output logic rise_o,
  output logic period_end_o
);

  localparam int               CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             lvl_q;
  logic             edge_w;

  // Counter wraps at CLK_DIV-1, so it never needs more than $clog2 bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
      lvl_q <= ~lvl_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Count 0 is the first cycle of each half period, i.e. the cycle in which
  // sclk_o shows its new level.
  assign edge_w       = en_i && (cnt_q == '0);
  assign fall_o       = edge_w && !lvl_q;
  assign rise_o       = edge_w && lvl_q;
  assign period_end_o = en_i && lvl_q && (cnt_q == CNT_MAX);
  assign sclk_o       = en_i ? lvl_q : 1'b1;

endmodule

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl -- byte-oriented SPI master sequencer (mode 3, sclk idles
// high). It drives chip select and sclk and issues strobes to external write
// and read shift registers; it holds no data itself.
//
// Handshake: a byte is accepted in any cycle where tx_valid_i and tx_ready_o
// are both high; load_data_en_o pulses in that same cycle. tx_last_i is only
// meaningful in an accepting cycle. tx_ready_o is high in IDLE, and (burst
// build only) in the final SHIFT cycle when a follow-on byte may chain.
//
// Build option: define SPI_MASTER_BURST_EN to let consecutive bytes share one
// chip-select window until a byte marked tx_last_i. Without it tx_last_i is
// only recorded on dbg_last_o and every byte gets its own CS_SETUP/CS_HOLD.
//
// Ports:
//   clk_i, rst_i     : system clock, asynchronous active-high reset
//   tx_valid_i       : byte transfer request
//   tx_last_i        : final byte of a burst (qualified by tx_valid_i)
//   tx_ready_o       : request accepted this cycle when tx_valid_i is high
//   load_data_en_o   : load strobe to the write shift register
//   wr_shift_en_o    : write-register shift strobe (sclk falling edges 2..8)
//   rd_shift_en_o    : read-register shift strobe (every sclk rising edge)
//   sclk_o, cs_n_o   : SPI clock (idle high), chip select (active low)
//   rx_done_o        : received byte complete in the read register
//   busy_o           : controller not in IDLE
//   dbg_state_o      : current FSM state (spi_state_e encoding)
//   dbg_last_o       : tx_last_i captured with the byte in flight
// ---------------------------------------------------------------------------
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_valid_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  output logic       load_data_en_o,
  output logic       wr_shift_en_o,
  output logic       rd_shift_en_o,
  output logic       sclk_o,
  output logic       cs_n_o,
  output logic       rx_done_o,
  output logic       busy_o,
  output logic [1:0] dbg_state_o,
  output logic       dbg_last_o
);

  localparam int               CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;   // CS_SETUP / CS_HOLD duration
  logic [3:0]       bit_q, bit_d;     // rising edges seen; bit 3 = byte done
  logic             last_q, last_d;

  logic tx_ready, load, rx_done;
  logic shift_en, sclk_fall, sclk_rise, period_end, sclk_lvl;

  assign shift_en = (state_q == ST_SHIFT);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (shift_en),
    .sclk_o       (sclk_lvl),
    .fall_o       (sclk_fall),
    .rise_o       (sclk_rise),
    .period_end_o (period_end)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      bit_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    bit_d    = bit_q;
    last_d   = last_q;
    tx_ready = 1'b0;
    load     = 1'b0;
    rx_done  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_ready = 1'b1;
        wait_d   = '0;
        bit_d    = '0;
        if (tx_valid_i) begin
          load    = 1'b1;
          last_d  = tx_last_i;
          state_d = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (wait_q == CNT_MAX) begin
          wait_d  = '0;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          bit_d = bit_q + 4'd1;
        end
        // The byte ends after the high phase following the 8th rising edge,
        // so the read register has already taken its last bit.
        if (bit_q[3] && period_end) begin
          rx_done = 1'b1;
`ifdef SPI_MASTER_BURST_EN
          if (tx_valid_i && !last_q) begin
            // Chain the next byte: the divider wraps straight into the
            // falling edge that opens it, keeping cs_n low throughout.
            tx_ready = 1'b1;
            load     = 1'b1;
            last_d   = tx_last_i;
            bit_d    = '0;
          end else begin
            state_d = ST_CS_HOLD;
          end
`else
          state_d = ST_CS_HOLD;
`endif
        end
      end
      ST_CS_HOLD: begin
        if (wait_q == CNT_MAX) begin
          wait_d  = '0;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Falling edge 1 needs no shift: the MSB is already out after the load.
  assign wr_shift_en_o  = sclk_fall && (bit_q != 4'd0);
  assign rd_shift_en_o  = sclk_rise;
  assign sclk_o         = sclk_lvl;
  // Decoded from the state register, so an asynchronous reset releases
  // chip select at once.
  assign cs_n_o         = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign rx_done_o      = rx_done;
  // Requests are refused outright while reset is held.
  assign tx_ready_o     = tx_ready && !rst_i;
  assign load_data_en_o = load && !rst_i;
  assign dbg_state_o    = state_q;
  assign dbg_last_o     = last_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl -- directed bench for spi_master_ctrl.
// u_dut  : CLK_DIV=4, cycle-by-cycle waveform checks, held request, abort.
// u_dut2 : CLK_DIV=2, loopback through bench-side write/read shift registers.
// Define SPI_MASTER_BURST_EN to also run the burst sequence.
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;

  localparam int DIV1   = 4;
  localparam int DIV2   = 2;
  // accept + setup + 16 half periods + hold
  localparam int PERIOD = 1 + DIV1 + 16 * DIV1 + DIV1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       tx_valid, tx_last, tx_ready, load, wr, rd, sclk, cs_n, rx_done, busy, dbg_last;
  logic [1:0] st;
  logic       tx_valid2, tx_ready2, load2, wr2, rd2, sclk2, cs_n2, rx_done2, busy2, dbg_last2;
  logic [1:0] st2;

  logic [7:0] tx_byte2;
  logic [7:0] wr_sr2, rd_sr2;
  logic [7:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  spi_master_ctrl #(.CLK_DIV(DIV1)) u_dut (
    .clk_i(clk), .rst_i(rst), .tx_valid_i(tx_valid), .tx_last_i(tx_last),
    .tx_ready_o(tx_ready), .load_data_en_o(load), .wr_shift_en_o(wr),
    .rd_shift_en_o(rd), .sclk_o(sclk), .cs_n_o(cs_n), .rx_done_o(rx_done),
    .busy_o(busy), .dbg_state_o(st), .dbg_last_o(dbg_last)
  );

  spi_master_ctrl #(.CLK_DIV(DIV2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .tx_valid_i(tx_valid2), .tx_last_i(1'b0),
    .tx_ready_o(tx_ready2), .load_data_en_o(load2), .wr_shift_en_o(wr2),
    .rd_shift_en_o(rd2), .sclk_o(sclk2), .cs_n_o(cs_n2), .rx_done_o(rx_done2),
    .busy_o(busy2), .dbg_state_o(st2), .dbg_last_o(dbg_last2)
  );

  // External shift registers, MOSI looped straight back to MISO.
  always @(posedge clk) begin
    if (load2)    wr_sr2 <= tx_byte2;
    else if (wr2) wr_sr2 <= {wr_sr2[6:0], 1'b0};
    if (rd2)      rd_sr2 <= {rd_sr2[6:0], wr_sr2[7]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {cs_n, sclk, load, wr, rd, rx_done, busy, tx_ready} at phase p of a byte
  // accepted at p=0 (req=0 means no request, i.e. plain idle).
  function automatic logic [7:0] exp_vec(input int p, input logic req);
    int k, half;
    logic lvl, edg;
    if (p == 0) return {1'b1, 1'b1, req, 5'b00001};
    if (p <= DIV1) return 8'b0100_0010;
    if (p <= DIV1 + 16 * DIV1) begin
      k    = p - DIV1 - 1;
      half = k / DIV1;
      lvl  = half[0];
      edg  = (k % DIV1) == 0;
      return {1'b0, lvl, 1'b0, edg && !lvl && (half >= 2), edg && lvl,
              k == 16 * DIV1 - 1, 1'b1, 1'b0};
    end
    if (p < PERIOD) return 8'b0100_0010;
    return 8'b1100_0001;
  endfunction

  // Drives u_dut for ncyc cycles (request at c=0, or held throughout) and
  // compares every cycle against exp_vec, then the per-byte strobe totals.
  task automatic run_trace(input int ncyc, input bit hold, input int nbytes, input string tag);
    int n_wr, n_rd, n_done, n_low, p;
    logic req;
    n_wr = 0; n_rd = 0; n_done = 0; n_low = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      tx_valid = hold || (c == 0);
      @(negedge clk);
      p   = c % PERIOD;
      req = hold || (c == 0);
      check($sformatf("%s_c%0d", tag, c),
            {24'd0, cs_n, sclk, load, wr, rd, rx_done, busy, tx_ready},
            {24'd0, exp_vec(p, req)});
      n_wr   += int'(wr);
      n_rd   += int'(rd);
      n_done += int'(rx_done);
      n_low  += int'(!cs_n);
    end
    check({tag, "_wr_pulses"}, n_wr, 7 * nbytes);
    check({tag, "_rd_pulses"}, n_rd, 8 * nbytes);
    check({tag, "_rx_done"},   n_done, nbytes);
    check({tag, "_cs_low"},    n_low, (PERIOD - 1) * nbytes);
  endtask

  initial begin
    int n_rise, n_done, n_cs_rise, n_load, n_edges, n_hold, got_done, cs_prev, sclk_prev;
    logic [7:0] bytes[4];
    logic [7:0] exp_b;

    rst = 1'b1; tx_valid = 1'b1; tx_last = 1'b0; tx_valid2 = 1'b0; tx_byte2 = 8'h00;

    // ---------------- reset state
    @(negedge clk);
    check("rst_outputs", {26'd0, cs_n, sclk, load, wr, rd, rx_done},
          {26'd0, 6'b110000});
    check("rst_busy_state", {29'd0, busy, st}, 32'd0);
    check("rst_dut2_idle", {28'd0, cs_n2, sclk2, load2, busy2}, {28'd0, 4'b1100});
    tx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, tx_ready}, 32'd1);

    // ---------------- single byte, full waveform
    run_trace(PERIOD + 1, 1'b0, 1, "single");
    check("single_last_flag", {31'd0, dbg_last}, 32'd0);

`ifndef SPI_MASTER_BURST_EN
    // ---------------- request held through two bytes
    run_trace(2 * PERIOD, 1'b1, 2, "held");
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    check("held_back_idle", {30'd0, cs_n, busy}, {30'd0, 2'b10});
`endif

    // ---------------- abort on the 5th rising sclk edge
    @(posedge clk); #1;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    n_rise = 0;
    for (int c = 0; c < 200 && n_rise < 5; c++) begin
      @(negedge clk);
      n_rise += int'(rd);
    end
    check("abort_reach_5th_rise", n_rise, 5);
    rst = 1'b1;
    #1;
    check("abort_async", {28'd0, cs_n, sclk, busy, rx_done}, {28'd0, 4'b1100});
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      n_done += int'(rx_done);
    end
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", {29'd0, tx_ready, st}, {29'd0, 3'b100});
    repeat (80) begin
      @(negedge clk);
      n_done += int'(rx_done) + int'(!cs_n);
    end
    check("abort_no_done", n_done, 0);

    // ---------------- loopback at CLK_DIV=2
    bytes[0] = 8'hA5; bytes[1] = 8'h00; bytes[2] = 8'hFF;
    bytes[3] = 8'($urandom_range(1, 254));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tx_valid2 = 1'b1;
      tx_byte2  = bytes[i];
      exp_q.push_back(bytes[i]);
      @(negedge clk);
      check($sformatf("lb_accept_%0d", i), {31'd0, load2}, 32'd1);
      @(posedge clk); #1;
      tx_valid2 = 1'b0;
      got_done = 0;
      for (int c = 0; c < 100 && got_done == 0; c++) begin
        @(negedge clk);
        if (rx_done2) got_done = 1;
      end
      check($sformatf("lb_done_seen_%0d", i), got_done, 1);
      if (got_done == 1 && exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        check($sformatf("lb_data_%0d", i), {24'd0, rd_sr2}, {24'd0, exp_b});
      end
      for (int c = 0; c < 20 && !tx_ready2; c++) @(negedge clk);
      check($sformatf("lb_back_idle_%0d", i), {31'd0, tx_ready2}, 32'd1);
    end
    check("lb_queue_empty", exp_q.size(), 0);
    check("lb_last_flag", {31'd0, dbg_last2}, 32'd0);

`ifdef SPI_MASTER_BURST_EN
    // ---------------- three-byte burst, tx_last on the third
    n_load = 0; n_done = 0; n_cs_rise = 0; n_edges = 0; n_hold = 0; n_rise = 0;
    cs_prev = 1; sclk_prev = 1;
    for (int c = 0; c < 206; c++) begin
      @(posedge clk); #1;
      tx_valid = (c == 0) || (c == 68) || (c == 132);
      tx_last  = (c == 132);
      @(negedge clk);
      n_load += int'(load);
      n_done += int'(rx_done);
      n_hold += int'(st == 2'd3);
      n_rise += int'(!cs_n);
      if (!cs_n && int'(sclk) != sclk_prev) n_edges++;
      if (cs_n && cs_prev == 0) n_cs_rise++;
      cs_prev   = int'(cs_n);
      sclk_prev = int'(sclk);
      if (c == 68 || c == 132) check($sformatf("burst_accept_c%0d", c),
                                     {30'd0, tx_ready, load}, {30'd0, 2'b11});
    end
    tx_valid = 1'b0; tx_last = 1'b0;
    check("burst_loads",   n_load, 3);
    check("burst_rx_done", n_done, 3);
    check("burst_cs_low",  n_rise, 200);
    check("burst_cs_gaps", n_cs_rise, 1);
    check("burst_edges",   n_edges, 48);
    check("burst_hold",    n_hold, DIV1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: sclk half-period in clk_i cycles; legal range 2..255.
REQ-002 SHALL have port clk_i, input, 1: single system clock.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port tx_valid_i, input, 1: byte transfer request.
REQ-005 SHALL have port tx_last_i, input, 1: final byte of burst, qualified by tx_valid_i.
REQ-006 SHALL have port tx_ready_o, output, 1: request accepted on the same cycle as tx_valid_i.
REQ-007 SHALL have port load_data_en_o, output, 1: one-cycle load strobe to the write shift register.
REQ-008 SHALL have port wr_shift_en_o, output, 1: one-cycle shift strobe to the write shift register on each sclk falling edge.
REQ-009 SHALL have port rd_shift_en_o, output, 1: one-cycle shift strobe to the read shift register on each sclk rising edge.
REQ-010 SHALL have port sclk_o, output, 1: SPI clock, idle high.
REQ-011 SHALL have port cs_n_o, output, 1: chip select, active-low.
REQ-012 SHALL have port rx_done_o, output, 1: one-cycle pulse when the received byte is complete in the read register.
REQ-013 SHALL have port busy_o, output, 1: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CS_SETUP, SHIFT, CS_HOLD.
REQ-015 IDLE: tx_ready_o=1, cs_n_o=1, sclk_o=1; on tx_valid_i, pulse load_data_en_o that cycle and go to CS_SETUP next cycle.
REQ-016 CS_SETUP: cs_n_o=0 for exactly CLK_DIV cycles; then SHIFT with bit counter at 0.
REQ-017 SHIFT: sclk_o SHALL toggle every CLK_DIV cycles, starting with a falling edge, for 16 edges total.
REQ-018 wr_shift_en_o SHALL pulse on falling edges 2..8 only; the first bit is already at the register MSB after load.
REQ-019 rd_shift_en_o SHALL pulse on every rising edge (8 per byte); the bit counter (3 bits plus done flag) increments on each.
REQ-020 Strobes SHALL be asserted in the same clk_i cycle that sclk_o changes level.
REQ-021 After the 8th rising edge, go to CS_HOLD; rx_done_o pulses in that transition cycle.
REQ-022 CS_HOLD: cs_n_o=0, sclk_o=1 for CLK_DIV cycles; then IDLE.
REQ-023 tx_ready_o SHALL be 0 outside IDLE; tx_valid_i held while busy is not accepted until IDLE.
REQ-024 The divider counter SHALL be $clog2(CLK_DIV) bits wide and wrap to 0 at CLK_DIV-1 with no overflow.

Reset
REQ-025 While rst_i=1: state IDLE, cs_n_o=1, sclk_o=1, all strobes 0, rx_done_o=0, busy_o=0, counters 0.
REQ-026 Reset asserted mid-transfer SHALL abort immediately; cs_n_o rises asynchronously and no rx_done_o is issued.

Configuration
REQ-027 Macro SPI_MASTER_BURST_EN: when defined, at the end of SHIFT with tx_valid_i=1 and the previous byte's tx_last_i=0, SHALL accept the next byte (tx_ready_o=1, load_data_en_o pulse), skip CS_HOLD and CS_SETUP, keep cs_n_o=0, and restart SHIFT.
REQ-028 Without SPI_MASTER_BURST_EN, tx_last_i SHALL be ignored and every byte SHALL use CS_SETUP/CS_HOLD with cs_n_o high for at least one cycle between bytes.

Structure
REQ-029 Package spi_pkg SHALL hold the FSM state enum typedef and the CLK_DIV default constant.
REQ-030 Sub-module spi_clk_div SHALL generate the sclk level plus rise/fall edge strobes from CLK_DIV, enabled only in SHIFT.

Verification
REQ-031 CLK_DIV=4, a single tx_valid_i pulse: load_data_en_o at cycle 0, cs_n_o low for 4+64+4 cycles, 7 wr_shift_en_o pulses, 8 rd_shift_en_o pulses, one rx_done_o.
REQ-032 tx_valid_i held high through a transfer without the burst macro: second accept only after IDLE, with cs_n_o high for at least 1 cycle between bytes.
REQ-033 SPI_MASTER_BURST_EN defined, 3 bytes with tx_last_i on the 3rd: cs_n_o continuously low across 48 sclk edges, then 3 rx_done_o pulses and CS_HOLD once.
REQ-034 rst_i asserted on the 5th rising edge: cs_n_o=1 and sclk_o=1 without waiting for a clock edge, no rx_done_o, tx_ready_o=1 after release.
REQ-035 Loopback with the write and read shift registers, CLK_DIV=2, byte 8'hA5: read register holds 8'hA5 when rx_done_o pulses.
